// File: rtl/clk_period_meter.sv
// Measures period, high time and low time of an asynchronous square wave in I_CLK cycles and flags a stuck input.
// Latency: input edge to rise is SYNC_STAGES+1 cycles, O_VALID one cycle after rise; no backpressure, results overwrite.
module clk_period_meter #(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT     = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic             I_CLK,
  input  logic             rst,
  input  logic             I_SIG,
  output logic [CNT_W-1:0] O_PERIOD,
  output logic [CNT_W-1:0] O_HIGH,
  output logic [CNT_W-1:0] O_LOW,
  output logic             O_VALID,
  output logic             O_STUCK,
  output logic             O_LEVEL
);

  typedef enum logic [1:0] {ST_IDLE, ST_MEAS, ST_STUCK} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  // Compare wide enough that a TIMEOUT above the counter range can never match
  localparam int CMP_W = (CNT_W > 32) ? CNT_W : 32;

  state_t r_state, w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [CNT_W-1:0]       r_hcnt, r_lcnt, r_since;
  logic [CNT_W-1:0]       r_period, r_high, r_low;
  logic                   r_valid, r_stuck, r_level;

  logic             w_s, w_rise, w_timeout;
  logic             w_latch, w_set_stuck, w_clr_stuck;
  logic [CNT_W:0]   w_sum;
  logic [CNT_W-1:0] w_period_sat;
  logic [CMP_W-1:0] w_since_ext;

  assign w_s          = r_sync[SYNC_STAGES-1];
  assign w_rise       = w_s & ~r_prev;
  assign w_sum        = {1'b0, r_hcnt} + {1'b0, r_lcnt};
  assign w_period_sat = w_sum[CNT_W] ? CNT_MAX : w_sum[CNT_W-1:0];
  assign w_since_ext  = CMP_W'(r_since);
  assign w_timeout    = (w_since_ext == CMP_W'(TIMEOUT));

  always_ff @(posedge I_CLK) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], I_SIG};
      r_prev <= w_s;
    end
  end

  always_ff @(posedge I_CLK) begin
    if (rst) begin
      r_hcnt  <= '0;
      r_lcnt  <= '0;
      r_since <= '0;
    end else if (w_rise) begin
      r_hcnt  <= CNT_ONE;
      r_lcnt  <= '0;
      r_since <= CNT_ONE;
    end else begin
      if (w_s) begin
        if (r_hcnt != CNT_MAX) r_hcnt <= r_hcnt + CNT_ONE;
      end else begin
        if (r_lcnt != CNT_MAX) r_lcnt <= r_lcnt + CNT_ONE;
      end
      if (r_since != CNT_MAX) r_since <= r_since + CNT_ONE;
    end
  end

  always_ff @(posedge I_CLK) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // The first rise after IDLE or STUCK only opens a measurement window
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_set_stuck = 1'b0;
    w_clr_stuck = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_state_nxt = ST_MEAS;
        end else if (w_timeout) begin
          w_state_nxt = ST_STUCK;
          w_set_stuck = 1'b1;
        end
      end
      ST_MEAS: begin
        if (w_rise) begin
          w_latch = 1'b1;
        end else if (w_timeout) begin
          w_state_nxt = ST_STUCK;
          w_set_stuck = 1'b1;
        end
      end
      ST_STUCK: begin
        if (w_rise) begin
          w_state_nxt = ST_MEAS;
          w_clr_stuck = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (rst) begin
      r_period <= '0;
      r_high   <= '0;
      r_low    <= '0;
      r_valid  <= 1'b0;
      r_stuck  <= 1'b0;
      r_level  <= 1'b0;
    end else begin
      r_valid <= w_latch;
      r_level <= w_s;
      if (w_latch) begin
        r_period <= w_period_sat;
        r_high   <= r_hcnt;
        r_low    <= r_lcnt;
      end
      if (w_set_stuck)      r_stuck <= 1'b1;
      else if (w_clr_stuck) r_stuck <= 1'b0;
    end
  end

  assign O_PERIOD = r_period;
  assign O_HIGH   = r_high;
  assign O_LOW    = r_low;
  assign O_VALID  = r_valid;
  assign O_STUCK  = r_stuck;
  assign O_LEVEL  = r_level;

endmodule

// File: tb/tb_clk_period_meter.sv
// Bench for clk_period_meter: directed waveforms push hand-computed results into per-DUT queues,
// negedge monitors pop and compare on every O_VALID. DUT a: CNT_W=32/TIMEOUT=64, DUT b: CNT_W=4/TIMEOUT=100.
module tb_clk_period_meter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sig_a, sig_b;
  logic [31:0] per_a, hi_a, lo_a;
  logic        vld_a, stk_a, lvl_a;
  logic [3:0]  per_b, hi_b, lo_b;
  logic        vld_b, stk_b, lvl_b;

  clk_period_meter #(.CNT_W(32), .TIMEOUT(64), .SYNC_STAGES(2)) u_dut_a (
    .I_CLK(clk), .rst(rst), .I_SIG(sig_a),
    .O_PERIOD(per_a), .O_HIGH(hi_a), .O_LOW(lo_a),
    .O_VALID(vld_a), .O_STUCK(stk_a), .O_LEVEL(lvl_a)
  );

  clk_period_meter #(.CNT_W(4), .TIMEOUT(100), .SYNC_STAGES(2)) u_dut_b (
    .I_CLK(clk), .rst(rst), .I_SIG(sig_b),
    .O_PERIOD(per_b), .O_HIGH(hi_b), .O_LOW(lo_b),
    .O_VALID(vld_b), .O_STUCK(stk_b), .O_LEVEL(lvl_b)
  );

  typedef struct packed {
    logic [31:0] p;
    logic [31:0] h;
    logic [31:0] l;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   armed_a  = 1'b0;
  bit   armed_b  = 1'b0;
  bit   prev_vld_a = 1'b0;
  bit   prev_vld_b = 1'b0;

  function automatic exp_t mk(input int p, input int h, input int l);
    exp_t r;
    r.p = p;
    r.h = h;
    r.l = l;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One rise per iteration; a rise that closes a full period expects a result
  task automatic wave(input bit on_b, input int h, input int l, input int n, input exp_t e);
    for (int k = 0; k < n; k++) begin
      if (on_b) begin
        sig_b = 1'b1;
        if (armed_b) q_b.push_back(e);
      end else begin
        sig_a = 1'b1;
        if (armed_a) q_a.push_back(e);
      end
      repeat (h) tick();
      if (on_b) sig_b = 1'b0;
      else      sig_a = 1'b0;
      repeat (l) tick();
      if (on_b) armed_b = 1'b1;
      else      armed_a = 1'b1;
    end
  endtask

  // Long enough low hold to reach STUCK on DUT a
  task automatic idle_a(input int n);
    repeat (n) tick();
    armed_a = 1'b0;
  endtask

  always @(negedge clk) begin
    if (vld_a) begin
      check("valid_a_back_to_back", {31'd0, prev_vld_a}, 32'd0);
      if (q_a.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL valid_a_unexpected: got O_VALID=1 (period %0d), expected no valid", per_a);
      end else begin
        e_a = q_a.pop_front();
        check("period_a", per_a, e_a.p);
        check("high_a", hi_a, e_a.h);
        check("low_a", lo_a, e_a.l);
      end
    end
    prev_vld_a = vld_a;
  end

  always @(negedge clk) begin
    if (vld_b) begin
      check("valid_b_back_to_back", {31'd0, prev_vld_b}, 32'd0);
      if (q_b.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL valid_b_unexpected: got O_VALID=1 (period %0d), expected no valid", per_b);
      end else begin
        e_b = q_b.pop_front();
        check("period_b", 32'(per_b), e_b.p);
        check("high_b", 32'(hi_b), e_b.h);
        check("low_b", 32'(lo_b), e_b.l);
      end
    end
    prev_vld_b = vld_b;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    int cyc;
    rst   = 1'b1;
    sig_a = 1'b0;
    sig_b = 1'b0;
    repeat (3) tick();
    check("rst_period", per_a, 32'd0);
    check("rst_high", hi_a, 32'd0);
    check("rst_low", lo_a, 32'd0);
    check("rst_valid", {31'd0, vld_a}, 32'd0);
    check("rst_stuck", {31'd0, stk_a}, 32'd0);
    check("rst_level", {31'd0, lvl_a}, 32'd0);
    rst = 1'b0;
    tick();

    // Divider num=2, num=5, then asymmetric 3/7
    wave(1'b0, 2, 2, 5, mk(4, 2, 2));
    idle_a(100);
    check("idle_stuck", {31'd0, stk_a}, 32'd1);
    check("idle_level", {31'd0, lvl_a}, 32'd0);
    wave(1'b0, 5, 5, 4, mk(10, 5, 5));
    idle_a(100);
    wave(1'b0, 3, 7, 4, mk(10, 3, 7));
    idle_a(100);

    // Stuck high: input edge + 3 cycles to rise, + 64 to STUCK
    wave(1'b0, 5, 5, 3, mk(10, 5, 5));
    check("pre_stuck", {31'd0, stk_a}, 32'd0);
    sig_a = 1'b1;
    q_a.push_back(mk(10, 5, 5));
    cyc = 0;
    while (!stk_a && cyc < 200) begin
      tick();
      cyc++;
    end
    check("stuck_latency", cyc, 32'd67);
    check("stuck_level", {31'd0, lvl_a}, 32'd1);
    repeat (20) tick();
    check("stuck_hold", {31'd0, stk_a}, 32'd1);
    sig_a   = 1'b0;
    armed_a = 1'b0;
    repeat (5) tick();
    sig_a = 1'b1;
    repeat (5) tick();
    check("stuck_cleared", {31'd0, stk_a}, 32'd0);
    sig_a = 1'b0;
    repeat (5) tick();
    armed_a = 1'b1;
    wave(1'b0, 5, 5, 2, mk(10, 5, 5));
    idle_a(100);

    // 4-bit counters saturate; TIMEOUT=100 is beyond their range
    wave(1'b1, 20, 20, 3, mk(15, 15, 15));
    repeat (40) tick();
    check("b_never_stuck", {31'd0, stk_b}, 32'd0);

    // Reset in the low phase of a measured period
    wave(1'b0, 4, 6, 3, mk(10, 4, 6));
    sig_a = 1'b1;
    q_a.push_back(mk(10, 4, 6));
    repeat (4) tick();
    sig_a = 1'b0;
    repeat (3) tick();
    check("pre_rst_period", per_a, 32'd10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_period", per_a, 32'd0);
    check("mid_rst_high", hi_a, 32'd0);
    check("mid_rst_low", lo_a, 32'd0);
    check("mid_rst_valid", {31'd0, vld_a}, 32'd0);
    check("mid_rst_stuck", {31'd0, stk_a}, 32'd0);
    check("mid_rst_level", {31'd0, lvl_a}, 32'd0);
    armed_a = 1'b0;
    armed_b = 1'b0;
    repeat (3) tick();
    wave(1'b0, 4, 6, 3, mk(10, 4, 6));

    repeat (20) tick();
    check("q_a_drained", q_a.size(), 32'd0);
    check("q_b_drained", q_b.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
